// File: rtl/memory_stage_pkg.sv
// Encodings shared with execute: one-hot opcode indices, load/store funct3 codes, FSM states.
// Also provides the `OPCODE_WIDTH header macro used by both stages.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif

package memory_stage_pkg;

    localparam int unsigned OPCODE_WIDTH = `OPCODE_WIDTH;

    localparam int unsigned OP_RTYPE  = 0;
    localparam int unsigned OP_ITYPE  = 1;
    localparam int unsigned OP_LOAD   = 2;
    localparam int unsigned OP_STORE  = 3;
    localparam int unsigned OP_BRANCH = 4;
    localparam int unsigned OP_JAL    = 5;
    localparam int unsigned OP_JALR   = 6;
    localparam int unsigned OP_LUI    = 7;
    localparam int unsigned OP_AUIPC  = 8;
    localparam int unsigned OP_SYSTEM = 9;
    localparam int unsigned OP_FENCE  = 10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] carries the access size, funct3[2] the unsigned flag
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_sel = 4'b0001 << off;
            SZ_HALF: lane_sel = 4'b0011 << {off[1], 1'b0};
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        is_misaligned = ((size == SZ_HALF) && off[0]) ||
                        ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/memory_stage_load_extend.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module load_extend
    import memory_stage_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [1:0]        off_i,
    input  logic [DWIDTH-1:0] rdata_i,
    output logic [DWIDTH-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{off_i, 3'b000} +: 8];
        // Half lane only looks at off[1], so odd offsets fall back to the aligned half
        half_v = rdata_i[{off_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: data_o = {{(DWIDTH-8){sign_i & byte_v[7]}}, byte_v};
            SZ_HALF: data_o = {{(DWIDTH-16){sign_i & half_v[15]}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: ALU pass-through, single-outstanding load/store bus master, writeback register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned AWIDTH      = 5,
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned FUNCT_WIDTH = 3
) (
    input  logic                    me_clk,
    input  logic                    me_rst,
    input  logic [OPCODE_WIDTH-1:0] me_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  me_i_funct3,
    input  logic [DWIDTH-1:0]       me_i_alu_value,
    input  logic [DWIDTH-1:0]       me_i_data_rs2,
    input  logic [AWIDTH-1:0]       me_i_addr_rd,
    input  logic                    me_i_we_reg,
    input  logic                    me_i_ce,
    input  logic                    me_i_flush,
    input  logic                    me_i_stall,
    output logic                    me_o_stall,
    output logic                    me_o_mem_req,
    output logic                    me_o_mem_we,
    output logic [DWIDTH-1:0]       me_o_mem_addr,
    output logic [DWIDTH-1:0]       me_o_mem_wdata,
    output logic [3:0]              me_o_mem_sel,
    input  logic                    me_i_mem_ack,
    input  logic [DWIDTH-1:0]       me_i_mem_rdata,
    output logic [AWIDTH-1:0]       me_o_addr_rd,
    output logic [DWIDTH-1:0]       me_o_data_rd,
    output logic                    me_o_we_reg,
    output logic                    me_o_ce,
    output logic                    me_o_misalign
);

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                mwe_q, mwe_d;
    logic [DWIDTH-1:0]   addr_q, addr_d;
    logic [3:0]          sel_q, sel_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d;
    logic [1:0]          off_q, off_d;
    logic [AWIDTH-1:0]   rd_q, rd_d;
    logic                load_q, load_d;
    logic                kill_q, kill_d;
    logic [DWIDTH-1:0]   hold_q, hold_d;
    logic                wb_ce_q, wb_ce_d;
    logic [DWIDTH-1:0]   wb_data_q, wb_data_d;
    logic [AWIDTH-1:0]   wb_rd_q, wb_rd_d;
    logic                wb_we_q, wb_we_d;
    logic                wb_mis_q, wb_mis_d;

    logic                accept;
    logic                is_mem;
    logic [1:0]          size_in;
    logic [1:0]          off_in;
    logic [DWIDTH-1:0]   rdata_sel;
    logic [DWIDTH-1:0]   ext_data;
    logic                unused_opcode;

    assign unused_opcode = ^me_i_opcode;
    assign accept  = (state_q == ST_IDLE) && me_i_ce && !me_i_stall && !me_i_flush;
    assign is_mem  = me_i_opcode[OP_LOAD] | me_i_opcode[OP_STORE];
    assign size_in = me_i_funct3[1:0];
    assign off_in  = me_i_alu_value[1:0];

    assign rdata_sel = (state_q == ST_DONE) ? hold_q : me_i_mem_rdata;

    load_extend #(
        .DWIDTH (DWIDTH)
    ) u_load_extend (
        .size_i  (size_q),
        .sign_i  (sign_q),
        .off_i   (off_q),
        .rdata_i (rdata_sel),
        .data_o  (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        mwe_d     = mwe_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        sign_d    = sign_q;
        off_d     = off_q;
        rd_d      = rd_q;
        load_d    = load_q;
        kill_d    = kill_q;
        hold_d    = hold_q;
        wb_ce_d   = wb_ce_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_we_d   = wb_we_q;
        wb_mis_d  = wb_mis_q;

        // Writeback holds while downstream stalls, otherwise ce/we/misalign are pulses
        if (!me_i_stall) begin
            wb_ce_d  = 1'b0;
            wb_we_d  = 1'b0;
            wb_mis_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_ce_d   = 1'b1;
                        wb_data_d = me_i_alu_value;
                        wb_rd_d   = me_i_addr_rd;
                        wb_we_d   = me_i_we_reg;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (is_misaligned(size_in, off_in)) begin
                        wb_ce_d   = 1'b1;
                        wb_data_d = me_i_alu_value;
                        wb_rd_d   = me_i_addr_rd;
                        wb_we_d   = 1'b0;
                        wb_mis_d  = 1'b1;
                    end
`endif
                    else begin
                        state_d = ST_BUSY;
                        req_d   = 1'b1;
                        mwe_d   = me_i_opcode[OP_STORE];
                        addr_d  = {me_i_alu_value[DWIDTH-1:2], 2'b00};
                        sel_d   = lane_sel(size_in, off_in);
                        case (size_in)
                            SZ_BYTE: wdata_d = {(DWIDTH/8){me_i_data_rs2[7:0]}};
                            SZ_HALF: wdata_d = {(DWIDTH/16){me_i_data_rs2[15:0]}};
                            default: wdata_d = me_i_data_rs2;
                        endcase
                        size_d  = size_in;
                        sign_d  = ~me_i_funct3[2];
                        off_d   = off_in;
                        rd_d    = me_i_addr_rd;
                        load_d  = me_i_opcode[OP_LOAD];
                        kill_d  = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                // A flush cannot abort the bus cycle; it only marks the result as dead
                kill_d = kill_q | me_i_flush;
                if (me_i_mem_ack) begin
                    req_d = 1'b0;
                    mwe_d = 1'b0;
                    if (me_i_stall) begin
                        hold_d  = me_i_mem_rdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                        if (!kill_d) begin
                            wb_ce_d   = 1'b1;
                            wb_data_d = load_q ? ext_data : '0;
                            wb_rd_d   = rd_q;
                            wb_we_d   = load_q;
                        end
                    end
                end
            end
            ST_DONE: begin
                kill_d = kill_q | me_i_flush;
                if (!me_i_stall) begin
                    state_d = ST_IDLE;
                    if (!kill_d) begin
                        wb_ce_d   = 1'b1;
                        wb_data_d = load_q ? ext_data : '0;
                        wb_rd_d   = rd_q;
                        wb_we_d   = load_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge me_clk or negedge me_rst) begin
        if (!me_rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            mwe_q     <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            sign_q    <= 1'b0;
            off_q     <= '0;
            rd_q      <= '0;
            load_q    <= 1'b0;
            kill_q    <= 1'b0;
            hold_q    <= '0;
            wb_ce_q   <= 1'b0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_mis_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            mwe_q     <= mwe_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            off_q     <= off_d;
            rd_q      <= rd_d;
            load_q    <= load_d;
            kill_q    <= kill_d;
            hold_q    <= hold_d;
            wb_ce_q   <= wb_ce_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
            wb_mis_q  <= wb_mis_d;
        end
    end

    // Gated by reset so every output reads 0 while reset is held
    assign me_o_stall     = me_rst & ((state_q != ST_IDLE) | me_i_stall);
    assign me_o_mem_req   = req_q;
    assign me_o_mem_we    = mwe_q;
    assign me_o_mem_addr  = addr_q;
    assign me_o_mem_sel   = sel_q;
    assign me_o_mem_wdata = wdata_q;
    assign me_o_addr_rd   = wb_rd_q;
    assign me_o_data_rd   = wb_data_q;
    assign me_o_we_reg    = wb_we_q;
    assign me_o_ce        = wb_ce_q;
    assign me_o_misalign  = wb_mis_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table with a result scoreboard, plus flush/stall/reset sequences.
module tb_memory_stage;
    import memory_stage_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic                    me_clk;
    logic                    me_rst;
    logic [OPCODE_WIDTH-1:0] me_i_opcode;
    logic [2:0]              me_i_funct3;
    logic [31:0]             me_i_alu_value;
    logic [31:0]             me_i_data_rs2;
    logic [4:0]              me_i_addr_rd;
    logic                    me_i_we_reg;
    logic                    me_i_ce;
    logic                    me_i_flush;
    logic                    me_i_stall;
    logic                    me_o_stall;
    logic                    me_o_mem_req;
    logic                    me_o_mem_we;
    logic [31:0]             me_o_mem_addr;
    logic [31:0]             me_o_mem_wdata;
    logic [3:0]              me_o_mem_sel;
    logic                    me_i_mem_ack;
    logic [31:0]             me_i_mem_rdata;
    logic [4:0]              me_o_addr_rd;
    logic [31:0]             me_o_data_rd;
    logic                    me_o_we_reg;
    logic                    me_o_ce;
    logic                    me_o_misalign;

    memory_stage #(
        .AWIDTH      (5),
        .DWIDTH      (32),
        .FUNCT_WIDTH (3)
    ) dut (
        .me_clk         (me_clk),
        .me_rst         (me_rst),
        .me_i_opcode    (me_i_opcode),
        .me_i_funct3    (me_i_funct3),
        .me_i_alu_value (me_i_alu_value),
        .me_i_data_rs2  (me_i_data_rs2),
        .me_i_addr_rd   (me_i_addr_rd),
        .me_i_we_reg    (me_i_we_reg),
        .me_i_ce        (me_i_ce),
        .me_i_flush     (me_i_flush),
        .me_i_stall     (me_i_stall),
        .me_o_stall     (me_o_stall),
        .me_o_mem_req   (me_o_mem_req),
        .me_o_mem_we    (me_o_mem_we),
        .me_o_mem_addr  (me_o_mem_addr),
        .me_o_mem_wdata (me_o_mem_wdata),
        .me_o_mem_sel   (me_o_mem_sel),
        .me_i_mem_ack   (me_i_mem_ack),
        .me_i_mem_rdata (me_i_mem_rdata),
        .me_o_addr_rd   (me_o_addr_rd),
        .me_o_data_rd   (me_o_data_rd),
        .me_o_we_reg    (me_o_we_reg),
        .me_o_ce        (me_o_ce),
        .me_o_misalign  (me_o_misalign)
    );

    typedef struct {
        logic [OPCODE_WIDTH-1:0] op;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        we;
        int unsigned dly;
        logic        bus;
        logic        mwe;
        logic [31:0] baddr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] res;
        logic        chk_res;
        logic        res_we;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        mis;
        logic        chk_data;
    } exp_t;

    localparam int unsigned NV = 14;
    vec_t        vt [NV];
    exp_t        sb [$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    initial me_clk = 1'b0;
    always #5 me_clk = ~me_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [OPCODE_WIDTH-1:0] onehot(input int unsigned idx);
        logic [OPCODE_WIDTH-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input int unsigned opi, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] rs2,
                                input logic [31:0] rdata, input logic [4:0] rd,
                                input logic we, input int unsigned dly, input logic bus,
                                input logic [31:0] baddr, input logic [3:0] sel,
                                input logic [31:0] wdata, input logic [31:0] res,
                                input logic chk_res, input logic res_we, input logic mis);
        vec_t v;
        v.op = onehot(opi);     v.f3 = f3;       v.alu = alu;     v.rs2 = rs2;
        v.rdata = rdata;        v.rd = rd;       v.we = we;       v.dly = dly;
        v.bus = bus;            v.mwe = (opi == OP_STORE);
        v.baddr = baddr;        v.sel = sel;     v.wdata = wdata; v.res = res;
        v.chk_res = chk_res;    v.res_we = res_we;                v.mis = mis;
        return v;
    endfunction

    task automatic step;
        @(posedge me_clk);
        #1;
    endtask

    task automatic drive(input logic [OPCODE_WIDTH-1:0] op, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic we);
        me_i_opcode = op; me_i_funct3 = f3; me_i_alu_value = alu;
        me_i_data_rs2 = rs2; me_i_addr_rd = rd; me_i_we_reg = we; me_i_ce = 1'b1;
    endtask

    task automatic idle_inputs;
        me_i_ce = 1'b0; me_i_opcode = '0; me_i_funct3 = '0; me_i_alu_value = '0;
        me_i_data_rs2 = '0; me_i_addr_rd = '0; me_i_we_reg = 1'b0;
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.sb: result seen with empty scoreboard", tag);
            return;
        end
        e = sb.pop_front();
        if (e.chk_data) chk({tag, ".data"}, me_o_data_rd, e.data);
        chk({tag, ".rd"}, 32'(me_o_addr_rd), 32'(e.rd));
        chk1({tag, ".we"}, me_o_we_reg, e.we);
        chk1({tag, ".mis"}, me_o_misalign, e.mis);
    endtask

    task automatic wait_result(input string tag);
        int unsigned n;
        n = 0;
        while (me_o_ce !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        if (me_o_ce !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.timeout: got ce=%b expected 1 within 16 cycles", tag, me_o_ce);
            return;
        end
        pop_cmp(tag);
        chk1({tag, ".noreq"}, me_o_mem_req, 1'b0);
        chk1({tag, ".stall_o"}, me_o_stall, 1'b0);
        step();
        chk1({tag, ".pulse"}, me_o_ce, 1'b0);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        step();
        drive(v.op, v.f3, v.alu, v.rs2, v.rd, v.we);
        sb.push_back('{v.res, v.rd, v.res_we, v.mis, v.chk_res});
        step();
        idle_inputs();
        if (v.bus) begin
            for (int unsigned k = 0; k <= v.dly; k++) begin
                chk1({tag, ".req"}, me_o_mem_req, 1'b1);
                chk1({tag, ".mwe"}, me_o_mem_we, v.mwe);
                chk({tag, ".addr"}, me_o_mem_addr, v.baddr);
                chk({tag, ".sel"}, 32'(me_o_mem_sel), 32'(v.sel));
                if (v.mwe) chk({tag, ".wdata"}, me_o_mem_wdata, v.wdata);
                chk1({tag, ".stall_busy"}, me_o_stall, 1'b1);
                chk1({tag, ".ce_busy"}, me_o_ce, 1'b0);
                if (k == v.dly) begin
                    me_i_mem_ack = 1'b1;
                    me_i_mem_rdata = v.rdata;
                end
                step();
                me_i_mem_ack = 1'b0;
                me_i_mem_rdata = 32'h5A5A_5A5A;
            end
        end else begin
            chk1({tag, ".nobus"}, me_o_mem_req, 1'b0);
        end
        wait_result(tag);
    endtask

    initial begin
        me_rst = 1'b0;
        me_i_flush = 1'b0;
        me_i_stall = 1'b1;
        me_i_mem_ack = 1'b0;
        me_i_mem_rdata = '0;
        idle_inputs();

        //          op        f3      alu           rs2           rdata         rd  we dly bus baddr         sel      wdata         res           chk we mis
        vt[0]  = mk(OP_RTYPE, 3'b000, 32'h0000_001E, 32'h0,        32'h0,        3,  1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_001E, 1, 1, 0);
        vt[1]  = mk(OP_ITYPE, 3'b000, 32'hFFFF_0001, 32'h0,        32'h0,        31, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'hFFFF_0001, 1, 0, 0);
        vt[2]  = mk(OP_STORE, F3_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,       0,  0, 2, 1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0, 0, 0);
        vt[3]  = mk(OP_LOAD,  F3_LB,  32'h0000_0103, 32'h0,        32'h80FF_FF12, 5, 1, 0, 1, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80, 1, 1, 0);
        vt[4]  = mk(OP_LOAD,  F3_LBU, 32'h0000_0103, 32'h0,        32'h80FF_FF12, 6, 1, 0, 1, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080, 1, 1, 0);
        vt[5]  = mk(OP_STORE, F3_SH,  32'h0000_0102, 32'h1234_ABCD, 32'h0,       0,  0, 1, 1, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0,        0, 0, 0);
        vt[6]  = mk(OP_STORE, F3_SB,  32'h0000_0101, 32'hAABB_CC77, 32'h0,       0,  0, 0, 1, 32'h0000_0100, 4'b0010, 32'h7777_7777, 32'h0,        0, 0, 0);
        vt[7]  = mk(OP_LOAD,  F3_LH,  32'h0000_0102, 32'h0,        32'h8001_7FFF, 7, 1, 1, 1, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_8001, 1, 1, 0);
        vt[8]  = mk(OP_LOAD,  F3_LHU, 32'h0000_0100, 32'h0,        32'h8001_F00D, 8, 1, 0, 1, 32'h0000_0100, 4'b0011, 32'h0,        32'h0000_F00D, 1, 1, 0);
        vt[9]  = mk(OP_LOAD,  F3_LW,  32'h0000_0200, 32'h0,        32'h1234_5678, 9, 1, 3, 1, 32'h0000_0200, 4'b1111, 32'h0,        32'h1234_5678, 1, 1, 0);
        vt[10] = TRAP ?
                 mk(OP_LOAD,  F3_LW,  32'h0000_0101, 32'h0,        32'hCAFE_F00D, 10, 1, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,         0, 0, 1) :
                 mk(OP_LOAD,  F3_LW,  32'h0000_0101, 32'h0,        32'hCAFE_F00D, 10, 1, 0, 1, 32'h0000_0100, 4'b1111, 32'h0,      32'hCAFE_F00D, 1, 1, 0);
        vt[11] = TRAP ?
                 mk(OP_LOAD,  F3_LH,  32'h0000_0103, 32'h0,        32'h7654_3210, 11, 1, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,         0, 0, 1) :
                 mk(OP_LOAD,  F3_LH,  32'h0000_0103, 32'h0,        32'h7654_3210, 11, 1, 0, 1, 32'h0000_0100, 4'b1100, 32'h0,      32'h0000_7654, 1, 1, 0);
        vt[12] = TRAP ?
                 mk(OP_STORE, F3_SW,  32'h0000_00FE, 32'h0BAD_CAFE, 32'h0,       0,  0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,         0, 0, 1) :
                 mk(OP_STORE, F3_SW,  32'h0000_00FE, 32'h0BAD_CAFE, 32'h0,       0,  0, 1, 1, 32'h0000_00FC, 4'b1111, 32'h0BAD_CAFE, 32'h0,        0, 0, 0);
        vt[13] = mk(OP_LOAD,  F3_LB,  32'h0000_0101, 32'h0,        32'h0000_7F00, 14, 1, 0, 1, 32'h0000_0100, 4'b0010, 32'h0,       32'h0000_007F, 1, 1, 0);

        // Reset state, including stall output gated while downstream stall is high
        #2;
        chk1("rst.stall_o", me_o_stall, 1'b0);
        chk1("rst.req", me_o_mem_req, 1'b0);
        chk1("rst.ce", me_o_ce, 1'b0);
        chk("rst.data", me_o_data_rd, 32'h0);
        chk("rst.addr", me_o_mem_addr, 32'h0);
        step();
        step();
        me_i_stall = 1'b0;
        me_rst = 1'b1;

        for (int unsigned i = 0; i < NV; i++)
            apply_vec(vt[i], $sformatf("v%0d", i));

        // Flush one cycle into the bus cycle: request held to ack, result dropped
        step();
        drive(onehot(OP_LOAD), F3_LW, 32'h0000_0200, 32'h0, 5'd13, 1'b1);
        step();
        idle_inputs();
        chk1("flush.req0", me_o_mem_req, 1'b1);
        step();
        chk1("flush.req1", me_o_mem_req, 1'b1);
        me_i_flush = 1'b1;
        step();
        me_i_flush = 1'b0;
        chk1("flush.req2", me_o_mem_req, 1'b1);
        chk("flush.addr", me_o_mem_addr, 32'h0000_0200);
        chk1("flush.ce2", me_o_ce, 1'b0);
        step();
        chk1("flush.req3", me_o_mem_req, 1'b1);
        me_i_mem_ack = 1'b1;
        me_i_mem_rdata = 32'h1111_2222;
        step();
        me_i_mem_ack = 1'b0;
        chk1("flush.req_drop", me_o_mem_req, 1'b0);
        chk1("flush.ce", me_o_ce, 1'b0);
        chk1("flush.we", me_o_we_reg, 1'b0);
        chk1("flush.stall_o", me_o_stall, 1'b0);
        step();
        chk1("flush.ce_late", me_o_ce, 1'b0);

        // Flush in IDLE refuses the incoming instruction
        drive(onehot(OP_RTYPE), 3'b000, 32'h0000_0042, 32'h0, 5'd4, 1'b1);
        me_i_flush = 1'b1;
        step();
        me_i_flush = 1'b0;
        idle_inputs();
        chk1("iflush.ce", me_o_ce, 1'b0);

        // Ack while stalled parks data in DONE; result waits for stall release, then holds under stall
        step();
        drive(onehot(OP_LOAD), F3_LHU, 32'h0000_0302, 32'h0, 5'd12, 1'b1);
        sb.push_back('{32'h0000_A5A5, 5'd12, 1'b1, 1'b0, 1'b1});
        step();
        idle_inputs();
        chk1("stall.req", me_o_mem_req, 1'b1);
        me_i_stall = 1'b1;
        me_i_mem_ack = 1'b1;
        me_i_mem_rdata = 32'hA5A5_0001;
        step();
        me_i_mem_ack = 1'b0;
        me_i_mem_rdata = 32'h0;
        chk1("stall.req_drop", me_o_mem_req, 1'b0);
        chk1("stall.stall_o0", me_o_stall, 1'b1);
        chk1("stall.ce0", me_o_ce, 1'b0);
        step();
        chk1("stall.ce1", me_o_ce, 1'b0);
        me_i_stall = 1'b0;
        chk1("stall.done_stall_o", me_o_stall, 1'b1);
        step();
        chk1("stall.ce_out", me_o_ce, 1'b1);
        pop_cmp("stall");
        me_i_stall = 1'b1;
        step();
        chk1("stall.hold_ce", me_o_ce, 1'b1);
        chk("stall.hold_data", me_o_data_rd, 32'h0000_A5A5);
        chk1("stall.hold_stall_o", me_o_stall, 1'b1);
        me_i_stall = 1'b0;
        step();
        chk1("stall.release_ce", me_o_ce, 1'b0);

        // Reset in the middle of a bus cycle clears everything without a clock
        step();
        drive(onehot(OP_STORE), F3_SW, 32'h0000_0400, 32'hFEED_FACE, 5'd0, 1'b0);
        step();
        idle_inputs();
        chk1("mrst.req_before", me_o_mem_req, 1'b1);
        me_i_stall = 1'b1;
        #1;
        me_rst = 1'b0;
        #1;
        chk1("mrst.req", me_o_mem_req, 1'b0);
        chk1("mrst.we", me_o_mem_we, 1'b0);
        chk("mrst.addr", me_o_mem_addr, 32'h0);
        chk("mrst.wdata", me_o_mem_wdata, 32'h0);
        chk("mrst.sel", 32'(me_o_mem_sel), 32'h0);
        chk1("mrst.stall_o", me_o_stall, 1'b0);
        chk1("mrst.ce", me_o_ce, 1'b0);
        me_i_stall = 1'b0;
        step();
        me_rst = 1'b1;
        apply_vec(vt[0], "post_rst");

        chk("sb.drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter AWIDTH, default 5, register-address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data/address width.
REQ-003 SHALL have parameter FUNCT_WIDTH, default 3, funct3 width.
REQ-004 SHALL have ports: me_clk in 1 clock; me_rst in 1 reset, asynchronous, active-low.
REQ-005 SHALL have port me_i_opcode in `OPCODE_WIDTH: one-hot opcode from execute.
REQ-006 SHALL have port me_i_funct3 in FUNCT_WIDTH: load/store size and sign.
REQ-007 SHALL have port me_i_alu_value in DWIDTH: ALU result or effective address.
REQ-008 SHALL have port me_i_data_rs2 in DWIDTH: store data.
REQ-009 SHALL have ports me_i_addr_rd in AWIDTH, me_i_we_reg in 1, me_i_ce in 1: destination, write enable, instruction valid.
REQ-010 SHALL have ports me_i_flush in 1 (kill current/incoming) and me_i_stall in 1 (downstream hold).
REQ-011 SHALL have port me_o_stall out 1: holds execute.
REQ-012 SHALL have bus ports: me_o_mem_req, me_o_mem_we out 1; me_o_mem_addr, me_o_mem_wdata out DWIDTH; me_o_mem_sel out 4; me_i_mem_ack in 1; me_i_mem_rdata in DWIDTH.
REQ-013 SHALL have outputs me_o_addr_rd AWIDTH, me_o_data_rd DWIDTH, me_o_we_reg 1, me_o_ce 1, me_o_misalign 1 to writeback.

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE; instruction accepted only in IDLE with me_i_ce=1, me_i_stall=0, me_i_flush=0.
REQ-015 SHALL pass non-LOAD/STORE instructions with 1-cycle latency: me_o_ce=1, me_o_data_rd=me_i_alu_value, rd/we copied.
REQ-016 SHALL on accepting LOAD/STORE go BUSY and, next cycle, drive me_o_mem_req=1, addr={alu_value[DWIDTH-1:2],2'b00}, we=1 for STORE only, holding all bus outputs stable until ack.
REQ-017 SHALL drive sel: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
REQ-018 SHALL replicate store data: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
REQ-019 SHALL on ack in BUSY drop req same edge, go IDLE, emit me_o_ce=1 with extended load data (LB/LH sign, LBU/LHU zero, LW raw), we_reg=1 for loads, 0 for stores.
REQ-020 SHALL, if ack arrives while me_i_stall=1, capture rdata and enter DONE, emitting result in the first cycle me_i_stall=0.
REQ-021 SHALL assert me_o_stall whenever state is BUSY or DONE, or me_i_stall=1; minimum load latency 2 cycles (accept -> result) with ack in the request cycle.
REQ-022 SHALL, on me_i_flush in BUSY, keep req until ack (no bus abort) but suppress the result (me_o_ce=0, me_o_we_reg=0).
REQ-023 SHALL hold all writeback outputs while me_i_stall=1; me_o_ce is a one-cycle pulse per instruction otherwise.

Reset
REQ-024 SHALL on me_rst=0 immediately force state IDLE and every output to 0, including mid-transaction (bus transaction abandoned).

Configuration
REQ-025 SHALL with MEM_MISALIGN_TRAP_EN defined detect misaligned LH/LHU/SH (a[0]=1) and LW/SW (a[1:0]!=0): no bus request, one-cycle me_o_ce=1, me_o_misalign=1, me_o_we_reg=0.
REQ-026 SHALL without MEM_MISALIGN_TRAP_EN force misaligned addresses to natural alignment and tie me_o_misalign to 0.

Structure
REQ-027 SHALL take `OPCODE_WIDTH, one-hot opcode indices (LOAD, STORE) and funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW) from the shared header used by execute.
REQ-028 SHALL place byte/half selection and sign/zero extension in sub-module load_extend (combinational).

Verification
REQ-029 ADD result alu_value=0x1E, rd=3, we=1 -> next cycle me_o_ce=1, data_rd=0x1E, rd=3, no mem_req.
REQ-030 SW addr 0x100, rs2=0xDEADBEEF, ack after 3 cycles -> req/we=1, addr 0x100, sel 4'b1111, wdata 0xDEADBEEF held 3 cycles, me_o_stall high, result we_reg=0.
REQ-031 LB then LBU addr 0x103, rdata 0x80FFFF12 -> data_rd 0xFFFFFF80 then 0x00000080, we_reg=1.
REQ-032 SH addr 0x102, rs2=0x1234ABCD -> sel 4'b1100, wdata 0xABCDABCD.
REQ-033 LW addr 0x200, flush 1 cycle after req, ack 2 cycles later -> req held until ack, me_o_ce stays 0; separate run: me_rst=0 during BUSY -> all outputs 0 at once.
REQ-034 LW addr 0x101 -> with MEM_MISALIGN_TRAP_EN: no req, me_o_misalign=1 pulse; without: req addr 0x100, misalign=0.
